qadd_accum: RTL and testbench

- Pipelined, parametrised sign-magnitude Q-format adder/subtractor with valid/ready handshakes on both sides.
- Adds a selectable saturation mode, a sticky overflow flag and an accumulate mode that keeps a running sum across beats. The running sum serves neuron dot-product reduction.
- Sits between the CORDIC/multiplier stages and the activation stage. Replaces the combinational adder on pipelined datapaths.

---
 rtl/qadd_pkg.sv | 28 ++
 rtl/qadd_sm_core.sv | 44 ++++
 rtl/qadd_accum.sv | 132 +++++++++++++
 tb/tb_qadd_accum.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qadd_pkg.sv
// Shared helpers for the sign-magnitude Q-format adder: field positions,
// saturation magnitude and the rule that forbids negative zero.
package qadd_pkg;

  localparam int QADD_N_DEFAULT = 32;
  localparam int QADD_Q_DEFAULT = 15;

  function automatic int sign_idx(input int n);
    return n - 1;
  endfunction

  function automatic int mag_msb(input int n);
    return n - 2;
  endfunction

  function automatic logic [63:0] max_mag(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // A zero magnitude always carries a positive sign.
  function automatic logic [63:0] norm_zero(input logic [63:0] v, input int n);
    if ((v & max_mag(n)) == 64'd0) begin
      return 64'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/qadd_sm_core.sv
// Combinational sign-magnitude add of x and y with clamp-or-wrap on
// magnitude overflow; the result is never negative zero.
module qadd_sm_core
  import qadd_pkg::*;
#(
  parameter int N   = QADD_N_DEFAULT,
  parameter bit SAT = 1'b1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam int SB = sign_idx(N);
  localparam int MB = mag_msb(N);
  localparam logic [N-2:0] MAXM = (N-1)'(max_mag(N));

  function automatic logic [N-2:0] ovf_mag(input logic [N-1:0] s);
    return SAT ? MAXM : s[MB:0];
  endfunction

  logic [N-1:0] sum;
  logic [N-2:0] mag;
  logic         sgn;

  always_comb begin
    sum = {1'b0, x[MB:0]} + {1'b0, y[MB:0]};
    ovf = 1'b0;
    mag = sum[MB:0];
    sgn = x[SB];
    if (x[SB] == y[SB]) begin
      ovf = sum[SB];
      if (sum[SB]) mag = ovf_mag(sum);
    end else if (x[MB:0] >= y[MB:0]) begin
      mag = x[MB:0] - y[MB:0];
    end else begin
      mag = y[MB:0] - x[MB:0];
      sgn = y[SB];
    end
    result = N'(norm_zero(64'({sgn, mag}), N));
  end

endmodule

// File: rtl/qadd_accum.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshakes and
// an accumulate mode that keeps a running sum (and sticky overflow) per run.
module qadd_accum
  import qadd_pkg::*;
#(
  parameter int N   = QADD_N_DEFAULT,
  parameter int Q   = QADD_Q_DEFAULT,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_acc,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  localparam int SB = sign_idx(N);
  localparam int MB = mag_msb(N);

  if (Q < 0 || Q >= N - 1) begin : g_q_check
    $error("qadd_accum: Q must lie in [0, N-2]");
  end

  logic         en;
  logic [N-1:0] a_p1_d, a_p1_q, b_p1_d, b_p1_q;
  logic         sub_p1_d, sub_p1_q, acc_p1_d, acc_p1_q, last_p1_d, last_p1_q;
  logic         vld_p1_d, vld_p1_q;
  logic [N-1:0] out_data_d, out_data_q, accum_d, accum_q;
  logic         out_ovf_d, out_ovf_q, out_valid_d, out_valid_q;
  logic         run_ovf_d, run_ovf_q;
  logic [N-1:0] y_p2, res_p2;
  logic         ovf_p2;

  // Single stall signal: everything advances unless a result is stuck.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Stage 1: capture the accepted beat, with the subtract folded into b.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    sub_p1_d  = sub_p1_q;
    acc_p1_d  = acc_p1_q;
    last_p1_d = last_p1_q;
    if (en) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        a_p1_d    = in_a;
        b_p1_d    = {in_b[SB] ^ in_sub, in_b[MB:0]};
        sub_p1_d  = in_sub;
        acc_p1_d  = in_acc;
        last_p1_d = in_last;
      end
    end
  end

  // Stage 2: add, then either emit or fold into the accumulator.
  assign y_p2 = acc_p1_q ? {accum_q[SB] ^ sub_p1_q, accum_q[MB:0]} : b_p1_q;

  qadd_sm_core #(.N(N), .SAT(SAT)) u_core (
    .x      (a_p1_q),
    .y      (y_p2),
    .result (res_p2),
    .ovf    (ovf_p2)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    accum_d     = accum_q;
    run_ovf_d   = run_ovf_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (vld_p1_q) begin
        if (!acc_p1_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_p2;
          out_ovf_d   = ovf_p2;
        end else if (last_p1_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_p2;
          out_ovf_d   = run_ovf_q | ovf_p2;
          accum_d     = '0;
          run_ovf_d   = 1'b0;
        end else begin
          accum_d   = res_p2;
          run_ovf_d = run_ovf_q | ovf_p2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      accum_q     <= '0;
      run_ovf_q   <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      accum_q     <= accum_d;
      run_ovf_q   <= run_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    sub_p1_q  <= sub_p1_d;
    acc_p1_q  <= acc_p1_d;
    last_p1_q <= last_p1_d;
  end

endmodule

// File: tb/tb_qadd_accum.sv
// Bench for qadd_accum: a saturating and a wrapping instance share one stimulus
// stream; directed tables plus random traffic against an integer-arithmetic model.
module tb_qadd_accum;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_sub = 1'b0, in_acc = 1'b0, in_last = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_ovf;
  logic [N-1:0] out_data;
  logic         in_ready_w, out_valid_w, out_ovf_w;
  logic [N-1:0] out_data_w;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  logic [32:0] exp_q1[$];
  logic [32:0] exp_q0[$];
  logic [31:0] m_acc1 = '0, m_acc0 = '0;
  bit          m_rovf1 = 1'b0, m_rovf0 = 1'b0;

  always #5 clk = ~clk;

  qadd_accum #(.N(N), .Q(15), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  qadd_accum #(.N(N), .Q(15), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: signed integer sum, then clamp or wrap the magnitude.
  function automatic logic [32:0] smadd(input logic [31:0] x, input logic [31:0] y, input bit sat);
    longint vx, vy, s, m;
    bit neg, ovf;
    vx = longint'(x[30:0]);
    if (x[31]) vx = -vx;
    vy = longint'(y[30:0]);
    if (y[31]) vy = -vy;
    s   = vx + vy;
    neg = (s < 0);
    m   = neg ? -s : s;
    ovf = (m > 64'h7FFF_FFFF);
    if (ovf) m = sat ? 64'h7FFF_FFFF : (m & 64'h7FFF_FFFF);
    if (m == 0) neg = 1'b0;
    return {ovf, neg, m[30:0]};
  endfunction

  function automatic logic [31:0] second_op(input logic [31:0] b, input logic [31:0] acc,
                                            input bit use_acc, input bit sub);
    logic [31:0] v;
    v = use_acc ? acc : b;
    return {v[31] ^ sub, v[30:0]};
  endfunction

  always @(negedge clk) begin
    logic [32:0] r, e;
    if (!rst_n) begin
      exp_q1.delete(); exp_q0.delete();
      m_acc1 = '0; m_acc0 = '0; m_rovf1 = 1'b0; m_rovf0 = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        r = smadd(in_a, second_op(in_b, m_acc1, in_acc, in_sub), 1'b1);
        if (!in_acc) exp_q1.push_back(r);
        else if (in_last) begin
          exp_q1.push_back({r[32] | m_rovf1, r[31:0]}); m_acc1 = '0; m_rovf1 = 1'b0;
        end else begin
          m_acc1 = r[31:0]; m_rovf1 = m_rovf1 | r[32];
        end
        r = smadd(in_a, second_op(in_b, m_acc0, in_acc, in_sub), 1'b0);
        if (!in_acc) exp_q0.push_back(r);
        else if (in_last) begin
          exp_q0.push_back({r[32] | m_rovf0, r[31:0]}); m_acc0 = '0; m_rovf0 = 1'b0;
        end else begin
          m_acc0 = r[31:0]; m_rovf0 = m_rovf0 | r[32];
        end
      end
      if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q1.size() == 0) begin
          n_checks++;
          $display("FAIL sb_sat_extra: got 0x%0h expected no output", out_data);
        end else begin
          e = exp_q1.pop_front();
          chk("sb_sat", 64'({out_ovf, out_data}), 64'(e));
        end
      end
      if (out_valid_w && out_ready) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          $display("FAIL sb_wrap_extra: got 0x%0h expected no output", out_data_w);
        end else begin
          e = exp_q0.pop_front();
          chk("sb_wrap", 64'({out_ovf_w, out_data_w}), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sub,
                      input bit acc, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_acc = acc; in_last = last;
    for (int g = 0; g < 100 && !ok; g++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 20 && cyc == 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) cyc = c;
    end
    if (cyc == 0) begin
      n_checks++;
      $display("FAIL wait_out_timeout: out_valid=%0b expected 1", out_valid);
    end
  endtask

  function automatic logic [31:0] rand_sm();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 3);
    if (k == 0) r[30:16] = 15'h7FFF;
    if (k == 1) r[30:16] = 15'h0000;
    if (k == 2) r[30:0]  = 31'h0;
    return r;
  endfunction

  typedef struct {
    logic [31:0] a, b;
    bit          sub;
    logic [31:0] e1;
    bit          o1;
    logic [31:0] e0;
    bit          o0;
  } vec_t;

  initial begin
    vec_t vt[8];
    int cyc, n0;
    bit done;
    logic [31:0] va;

    vt[0] = '{32'h0000C000, 32'h00012000, 1'b0, 32'h0001E000, 1'b0, 32'h0001E000, 1'b0};
    vt[1] = '{32'h00008000, 32'h00008000, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vt[2] = '{32'h80008000, 32'h00008000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vt[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
    vt[6] = '{32'h00001000, 32'h00003000, 1'b1, 32'h80002000, 1'b0, 32'h80002000, 1'b0};
    vt[7] = '{32'h80005000, 32'h00002000, 1'b0, 32'h80003000, 1'b0, 32'h80003000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].b, vt[i].sub, 1'b0, 1'b0);
      idle();
      wait_out(cyc);
      chk($sformatf("latency_%0d", i), 64'(cyc + 1), 64'd2);
      chk($sformatf("vec_sat_%0d", i), 64'({out_ovf, out_data}), 64'({vt[i].o1, vt[i].e1}));
      chk($sformatf("vec_wrap_%0d", i), 64'({out_ovf_w, out_data_w}), 64'({vt[i].o0, vt[i].e0}));
    end
    repeat (2) @(posedge clk);
    #1;

    n0 = n_out;
    send(32'h00008000, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h80004000, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h00010000, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(cyc);
    chk("acc_run", 64'({out_ovf, out_data}), 64'({1'b0, 32'h00014000}));
    repeat (3) @(posedge clk);
    #1;
    chk("acc_single_output", 64'(n_out - n0), 64'd1);
    send(32'h00008000, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(cyc);
    chk("acc_cleared", 64'({out_ovf, out_data}), 64'({1'b0, 32'h00008000}));
    repeat (2) @(posedge clk);
    #1;

    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_sm(), rand_sm(), 1'(i % 2), 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("stall_six_outputs", 64'(n_out - n0), 64'd6);

    n0 = n_out;
    send(32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h00000001, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h80000001, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(cyc);
    chk("ovf_run_sat", 64'({out_ovf, out_data}), 64'({1'b1, 32'h7FFFFFFE}));
    chk("ovf_run_wrap", 64'({out_ovf_w, out_data_w}), 64'({1'b1, 32'h80000001}));
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_run_one_output", 64'(n_out - n0), 64'd1);
    send(32'h00000100, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(cyc);
    chk("ovf_sticky_cleared", 64'({out_ovf, out_data}), 64'({1'b0, 32'h00000100}));
    repeat (2) @(posedge clk);
    #1;

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          bit acc;
          acc = ($urandom_range(0, 2) != 0);
          send(rand_sm(), rand_sm(), 1'($urandom_range(0, 1)), acc,
               acc && ($urandom_range(0, 3) == 0));
        end
        send(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("random_drain_sat", 64'(exp_q1.size()), 64'd0);
    chk("random_drain_wrap", 64'(exp_q0.size()), 64'd0);

    send(32'h00001000, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h00002000, 32'h0, 1'b0, 1'b1, 1'b0);
    send(32'h00005555, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    wait_out(cyc);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'({out_valid, out_valid_w}), 64'd0);
    chk("async_rst_data", 64'({out_data, out_data_w}), 64'd0);
    chk("async_rst_ovf", 64'({out_ovf, out_ovf_w}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    send(32'h00004000, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(cyc);
    chk("post_rst_acc_sat", 64'({out_ovf, out_data}), 64'({1'b0, 32'h00004000}));
    chk("post_rst_acc_wrap", 64'({out_ovf_w, out_data_w}), 64'({1'b0, 32'h00004000}));
    repeat (3) @(posedge clk);
    #1;
    va = 32'(exp_q1.size() + exp_q0.size());
    chk("final_drain", 64'(va), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
